// File: rtl/audio_fir_decim_if.sv
// FIFO-facing bus of the audio decimating FIR: pops demod samples, pushes audio samples.
interface audio_fir_decim_if;
    logic               in_empty;
    logic               in_rd_en;
    logic signed [31:0] x_in;
    logic signed [31:0] y_out;
    logic               out_wr_en;
    logic               out_full;

    modport master (
        input  in_empty, x_in, out_full,
        output in_rd_en, y_out, out_wr_en
    );

    modport slave (
        output in_empty, x_in, out_full,
        input  in_rd_en, y_out, out_wr_en
    );
endinterface

// File: rtl/audio_fir_decim.sv
// Time-multiplexed real FIR low-pass with integer decimation for the audio path.
// Collects DECIM samples, then runs one tap per cycle through a single multiplier.
module audio_fir_decim #(
    parameter int unsigned        TAPS          = 32,
    parameter int unsigned        DECIM         = 8,
    parameter int unsigned        BITS          = 10,
    parameter logic signed [31:0] COEFFS [TAPS] = '{default: 32'sd0}
) (
    input  logic              clk,
    input  logic              reset,
    audio_fir_decim_if.master fifo
);
    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {FILL, MAC, OUTPUT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [TAP_W-1:0]   tap;
    logic signed [31:0] acc;
    logic signed [31:0] y_q;
    logic signed [31:0] x_sr [TAPS];
    logic signed [63:0] prod_c;
    logic signed [31:0] acc_next_c;

    // Strobes are gated by reset so nothing is popped or pushed while held in reset.
    assign fifo.in_rd_en  = reset && (state == FILL)   && !fifo.in_empty;
    assign fifo.out_wr_en = reset && (state == OUTPUT) && !fifo.out_full;
    assign fifo.y_out     = y_q;

    // Single shared multiplier; product is floored by the arithmetic shift, then wraps.
    assign prod_c     = 64'(x_sr[tap]) * 64'(COEFFS[tap]);
    assign acc_next_c = acc + 32'(prod_c >>> BITS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
            cnt   <= '0;
            tap   <= '0;
            acc   <= '0;
            y_q   <= '0;
            for (int unsigned k = 0; k < TAPS; k++) x_sr[k] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (!fifo.in_empty) begin
                        x_sr[0] <= fifo.x_in;
                        for (int unsigned k = 1; k < TAPS; k++) x_sr[k] <= x_sr[k-1];
                        if (cnt == CNT_W'(DECIM - 1)) begin
                            cnt   <= '0;
                            acc   <= '0;
                            tap   <= '0;
                            state <= MAC;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                MAC: begin
                    acc <= acc_next_c;
                    if (tap == TAP_W'(TAPS - 1)) begin
                        y_q   <= acc_next_c;
                        state <= OUTPUT;
                    end else begin
                        tap <= tap + TAP_W'(1);
                    end
                end
                OUTPUT: begin
                    if (!fifo.out_full) state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_fir_decim.sv
// Self-checking bench for audio_fir_decim: directed corner sequences, a DECIM=1 vector
// table on a second instance, and randomized traffic against a convolution reference.
module tb_audio_fir_decim;
    localparam int unsigned TAPS  = 32;
    localparam int unsigned DECIM = 8;
    localparam int unsigned BITS  = 10;

    localparam logic signed [31:0] H [TAPS] = '{
        32'sd1,  32'sd2,  32'sd3,  32'sd4,  32'sd5,  32'sd6,  32'sd7,  32'sd8,
        32'sd9,  32'sd10, 32'sd11, 32'sd12, 32'sd13, 32'sd14, 32'sd15, 32'sd16,
        32'sd17, 32'sd18, 32'sd19, 32'sd20, 32'sd21, 32'sd22, 32'sd23, 32'sd24,
        32'sd25, 32'sd26, 32'sd27, 32'sd28, 32'sd29, 32'sd30, 32'sd31, 32'sd32};
    localparam logic signed [31:0] H2 [4] = '{32'sd1, 32'sd0, 32'sd0, 32'sd0};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    audio_fir_decim_if bus ();
    audio_fir_decim_if bus2 ();

    audio_fir_decim #(.TAPS(TAPS), .DECIM(DECIM), .BITS(BITS), .COEFFS(H)) dut (
        .clk(clk), .reset(reset), .fifo(bus.master));
    audio_fir_decim #(.TAPS(4), .DECIM(1), .BITS(BITS), .COEFFS(H2)) dut2 (
        .clk(clk), .reset(reset), .fifo(bus2.master));

    typedef struct { int x; int y; } vec_t;

    int total = 0;
    int bad   = 0;
    int hist[$];
    int exp_q[$];
    int got[$];
    int src[$];
    int pop_steps[$];
    int wr_steps[$];
    int src_idx;
    int pops;
    int stepno;

    function automatic void check(string name, int act, int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endfunction

    // y[n] = sum_k floor(h[k]*x[n-k] / 2^BITS), 32-bit wrap; missing history counts as zero.
    function automatic int ref_y();
        int     acc;
        int     n;
        longint xv;
        longint p;
        acc = 0;
        n   = hist.size();
        for (int k = 0; k < int'(TAPS); k++) begin
            xv  = (k < n) ? longint'(hist[n-1-k]) : 64'sd0;
            p   = xv * longint'(H[k]);
            acc += int'(p >>> BITS);
        end
        return acc;
    endfunction

    task automatic clear_model();
        hist.delete(); exp_q.delete(); got.delete(); src.delete();
        pop_steps.delete(); wr_steps.delete();
        src_idx = 0; pops = 0; stepno = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.in_empty = 1'b0; bus.out_full = 1'b0; bus.x_in = 32'sd5;
        clear_model();
        @(negedge clk);
        #1;
        check("rst_in_rd_en", int'(bus.in_rd_en), 0);
        check("rst_out_wr_en", int'(bus.out_wr_en), 0);
        check("rst_y_out", int'(bus.y_out), 0);
        bus.in_empty = 1'b1; bus.out_full = 1'b1;
        reset = 1'b1;
    endtask

    task automatic step(input bit empty, input bit full);
        @(negedge clk);
        bus.in_empty = empty;
        bus.out_full = full;
        bus.x_in     = (src_idx < src.size()) ? src[src_idx] : 0;
        #1;
        if (empty) check("pop_while_empty", int'(bus.in_rd_en), 0);
        if (bus.in_rd_en) begin
            hist.push_back(int'(bus.x_in));
            pop_steps.push_back(stepno);
            src_idx++;
            pops++;
            if (pops % int'(DECIM) == 0) exp_q.push_back(ref_y());
        end
        if (bus.out_wr_en) begin
            got.push_back(int'(bus.y_out));
            wr_steps.push_back(stepno);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got y=%0d want no write", int'(bus.y_out));
            end else begin
                check("y_vs_model", int'(bus.y_out), exp_q.pop_front());
            end
        end
        stepno++;
    endtask

    task automatic run_until(input int n, input int budget, input int mode);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            step((mode == 1) ? c[0] : 1'b0, 1'b0);
            c++;
        end
        if (got.size() < n) begin
            total++; bad++;
            $display("FAIL write_timeout: got %0d writes want %0d", got.size(), n);
        end
    endtask

    task automatic load_impulse();
        src.push_back(1024);
        for (int i = 0; i < 80; i++) src.push_back(0);
    endtask

    task automatic load_dc();
        for (int i = 0; i < 80; i++) src.push_back(1024);
    endtask

    initial begin
        vec_t vt[7];
        int   imp_exp[5];
        int   dc_exp[5];
        bit   seen;

        reset = 1'b0;
        bus.in_empty = 1'b1; bus.out_full = 1'b1; bus.x_in = '0;
        bus2.in_empty = 1'b1; bus2.out_full = 1'b0; bus2.x_in = '0;
        imp_exp = '{8, 16, 24, 32, 0};
        dc_exp  = '{36, 136, 300, 528, 528};

        // Impulse response, latency and one write per DECIM pops
        do_reset();
        load_impulse();
        run_until(5, 400, 0);
        for (int i = 0; i < 5 && i < got.size(); i++) check("impulse_y", got[i], imp_exp[i]);
        check("impulse_pops_per_write", pops, 5 * int'(DECIM));
        if (wr_steps.size() > 0 && pop_steps.size() >= int'(DECIM))
            check("latency", wr_steps[0] - pop_steps[DECIM-1], int'(TAPS) + 1);

        // DC ramp-up and steady-state throughput
        do_reset();
        load_dc();
        run_until(5, 400, 0);
        for (int i = 0; i < 5 && i < got.size(); i++) check("dc_y", got[i], dc_exp[i]);
        if (wr_steps.size() >= 5)
            check("throughput", wr_steps[4] - wr_steps[3], int'(DECIM + TAPS) + 1);

        // Backpressure held for 20 cycles in OUTPUT
        do_reset();
        load_dc();
        for (int i = 0; i < int'(DECIM + TAPS); i++) step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            check("bp_out_wr_en", int'(bus.out_wr_en), 0);
            check("bp_in_rd_en", int'(bus.in_rd_en), 0);
            check("bp_y_stable", int'(bus.y_out), 36);
        end
        step(1'b0, 1'b0);
        check("bp_release_wr", int'(bus.out_wr_en), 1);
        check("bp_write_count", got.size(), 1);

        // Starved input: empty toggles every cycle
        do_reset();
        load_dc();
        run_until(4, 600, 1);
        for (int i = 0; i < 4 && i < got.size(); i++) check("starve_y", got[i], dc_exp[i]);
        check("starve_pops", pops, 4 * int'(DECIM));

        // Reset while the MAC is at tap 10, then rerun the impulse
        do_reset();
        load_impulse();
        for (int i = 0; i < int'(DECIM) + 10; i++) step(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus.in_empty = 1'b1;
        #1;
        check("abort_no_write", int'(bus.out_wr_en), 0);
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        load_impulse();
        run_until(2, 200, 0);
        if (got.size() >= 2) begin
            check("restart_y0", got[0], 8);
            check("restart_y1", got[1], 16);
        end

        // DECIM=1 single-tap instance: floor and wrap of the Q10 product
        vt[0] = '{-1, -1};
        vt[1] = '{-2048, -2};
        vt[2] = '{1024, 1};
        vt[3] = '{1023, 0};
        vt[4] = '{-1025, -2};
        vt[5] = '{32'h7fffffff, 2097151};
        vt[6] = '{32'h80000000, -2097152};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus2.x_in = vt[i].x;
            bus2.in_empty = 1'b0;
            #1;
            check("dut2_pop", int'(bus2.in_rd_en), 1);
            @(negedge clk);
            bus2.in_empty = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                #1;
                if (bus2.out_wr_en) begin
                    seen = 1'b1;
                    check("dut2_y", int'(bus2.y_out), vt[i].y);
                end else begin
                    @(negedge clk);
                end
            end
            if (!seen) begin
                total++; bad++;
                $display("FAIL dut2_timeout: vector %0d got no write want y=%0d", i, vt[i].y);
            end
        end

        // Randomized traffic with random stalls and backpressure
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) src.push_back(int'($urandom()));
            else src.push_back(int'($urandom_range(0, 8191)) - 4096);
        end
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        check("rand_frame_count", got.size() + exp_q.size(), pops / int'(DECIM));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
